// File: rtl/clock_ui_pkg.sv
// Shared screen, cursor and FSM encodings for the clock front panel,
// plus the edit-cursor sequencing helpers.
package clock_ui_pkg;

    typedef enum logic [1:0] {
        SCR_TIME = 2'd0,
        SCR_DATE = 2'd1,
        SCR_TZ   = 2'd2
    } screen_t;

    localparam logic [2:0] POS_HT   = 3'd0;
    localparam logic [2:0] POS_HU   = 3'd1;
    localparam logic [2:0] POS_MT   = 3'd2;
    localparam logic [2:0] POS_MU   = 3'd3;
    localparam logic [2:0] POS_ST   = 3'd4;
    localparam logic [2:0] POS_SU   = 3'd5;
    localparam logic [2:0] POS_AMPM = 3'd7;

    typedef enum logic {
        ST_VIEW,
        ST_EDIT
    } top_state_t;

    typedef enum logic [1:0] {
        REP_REL,
        REP_HOLD,
        REP_RPT
    } rep_state_t;

    // 12 h edits the hour as one field at POS_HT and adds the AM/PM field.
    function automatic logic pos_valid(input logic [2:0] pos, input logic mode12);
        if (mode12)
            return (pos != POS_HU) && (pos != 3'd6);
        return pos <= POS_SU;
    endfunction

    function automatic logic [2:0] next_pos(input logic [2:0] pos, input logic mode12);
        logic [2:0] nxt;
        case (pos)
            POS_HT:   nxt = mode12 ? POS_MT : POS_HU;
            POS_SU:   nxt = mode12 ? POS_AMPM : POS_HT;
            POS_AMPM: nxt = POS_HT;
            default:  nxt = pos + 3'd1;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Debounces one active-low push-button into a pressed level and a
// one-cycle press strobe that rises together with the level.
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC);

    logic [CNT_W-1:0] cnt;

    // Any sample agreeing with the current level restarts the stability count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (~key_n == level) begin
                cnt <= '0;
            end else if (cnt >= CNT_W'(DEBOUNCE_CYC - 1)) begin
                cnt   <= '0;
                level <= ~key_n;
                press <= ~key_n;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/time_edit_sequencer.sv
// Front-panel controller: view/edit FSM, edit cursor, inc/dec strobes with
// hold-to-repeat, gated 1 Hz tick and the digit flicker clock.
module time_edit_sequencer
    import clock_ui_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned REPEAT_DELAY = 25_000_000,
    parameter int unsigned REPEAT_RATE  = 5_000_000,
    parameter int unsigned FLICK_HALF   = 12_500_000,
    parameter int unsigned EDIT_TIMEOUT = 500_000_000
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       en,
    input  logic       mode12,
    input  logic [3:0] key_n,
    output logic [1:0] screen,
    output logic       edit_mode,
    output logic [2:0] edit_pos,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       tick_1hz,
    output logic       flick
);
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned TICK_W  = $clog2(CLK_HZ);
    localparam int unsigned FLICK_W = $clog2(FLICK_HALF);
    localparam int unsigned REP_W   = $clog2(REP_MAX);
    localparam int unsigned TMO_W   = $clog2(EDIT_TIMEOUT);

    logic               clr;
    logic [3:0]         lvl;
    logic [3:0]         press;
    logic               unused_lvl;
    top_state_t         state;
    screen_t            scr;
    rep_state_t         rep_state, rep_next;
    logic               rep_dec, rep_dec_next;
    logic               blocked;
    logic [TICK_W-1:0]  tick_cnt;
    logic [FLICK_W-1:0] flick_cnt;
    logic [REP_W-1:0]   rep_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               tick_wrap, flick_wrap, both, rep_hit, fire;
    logic               enter_edit, exit_edit, edit_next;
    logic [2:0]         pos_cur;

    assign clr        = rst | ~en;
    assign unused_lvl = ^{lvl[3], lvl[0]};

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
            .clk   (CLOCK_50),
            .rst   (clr),
            .key_n (key_n[i]),
            .level (lvl[i]),
            .press (press[i])
        );
    end

    always_comb begin
        tick_wrap  = tick_cnt >= TICK_W'(CLK_HZ - 1);
        flick_wrap = flick_cnt >= FLICK_W'(FLICK_HALF - 1);
        both       = lvl[1] & lvl[2];
        enter_edit = (state == ST_VIEW) && press[3] && (scr == SCR_TIME);
        exit_edit  = (state == ST_EDIT) &&
                     (press[3] || ((press == 4'b0000) && (tmo_cnt >= TMO_W'(EDIT_TIMEOUT - 1))));
        edit_next  = (state == ST_EDIT) ? !exit_edit : enter_edit;
        pos_cur    = pos_valid(edit_pos, mode12) ? edit_pos : POS_HT;
        rep_hit    = rep_cnt >= ((rep_state == REP_HOLD) ? REP_W'(REPEAT_DELAY - 1)
                                                         : REP_W'(REPEAT_RATE - 1));
        rep_next     = rep_state;
        rep_dec_next = rep_dec;
        fire         = 1'b0;
        // Leaving edit suppresses any strobe decided in the same cycle.
        if ((state != ST_EDIT) || exit_edit || both) begin
            rep_next = REP_REL;
        end else begin
            case (rep_state)
                REP_REL: begin
                    if (!blocked && press[1]) begin
                        rep_next     = REP_HOLD;
                        rep_dec_next = 1'b0;
                        fire         = 1'b1;
                    end else if (!blocked && press[2]) begin
                        rep_next     = REP_HOLD;
                        rep_dec_next = 1'b1;
                        fire         = 1'b1;
                    end
                end
                default: begin
                    if (!(rep_dec ? lvl[2] : lvl[1])) begin
                        rep_next = REP_REL;
                    end else if (rep_hit) begin
                        rep_next = REP_RPT;
                        fire     = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (clr) begin
            state     <= ST_VIEW;
            scr       <= SCR_TIME;
            edit_pos  <= POS_HT;
            rep_state <= REP_REL;
            rep_dec   <= 1'b0;
            blocked   <= 1'b0;
            rep_cnt   <= '0;
            tmo_cnt   <= '0;
            tick_cnt  <= '0;
            flick_cnt <= '0;
            inc_pulse <= 1'b0;
            dec_pulse <= 1'b0;
            tick_1hz  <= 1'b0;
            flick     <= 1'b0;
        end else begin
            // The tick counter keeps its phase through edit; only the strobe is gated.
            tick_cnt  <= tick_wrap ? '0 : tick_cnt + 1'b1;
            tick_1hz  <= tick_wrap & ~edit_next;
            flick_cnt <= flick_wrap ? '0 : flick_cnt + 1'b1;
            if (flick_wrap)
                flick <= ~flick;

            state     <= edit_next ? ST_EDIT : ST_VIEW;
            rep_state <= rep_next;
            rep_dec   <= rep_dec_next;
            inc_pulse <= fire & ~rep_dec_next;
            dec_pulse <= fire & rep_dec_next;
            rep_cnt   <= (fire || (rep_next == REP_REL)) ? '0 : rep_cnt + 1'b1;

            if (state != ST_EDIT)
                blocked <= 1'b0;
            else if (both)
                blocked <= 1'b1;
            else if (!lvl[1] && !lvl[2])
                blocked <= 1'b0;

            tmo_cnt <= ((state != ST_EDIT) || (press != 4'b0000) || fire) ? '0 : tmo_cnt + 1'b1;

            if (state == ST_VIEW) begin
                edit_pos <= POS_HT;
                if (press[0] && !enter_edit) begin
                    case (scr)
                        SCR_TIME: scr <= SCR_DATE;
                        SCR_DATE: scr <= SCR_TZ;
                        default:  scr <= SCR_TIME;
                    endcase
                end
            end else if (exit_edit) begin
                edit_pos <= POS_HT;
            end else begin
                edit_pos <= press[0] ? next_pos(pos_cur, mode12) : pos_cur;
            end
        end
    end

    assign screen    = scr;
    assign edit_mode = (state == ST_EDIT);

endmodule
